aes_decrypt_core: RTL and testbench



---
 rtl/aes_decrypt_core.sv | 163 ++++++++++++++++
 tb/tb_aes_decrypt_core.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 inverse cipher: sequences the rounds and performs InvShiftRows,
// AddRoundKey and column-serial InvMixColumns; InvSubBytes is supplied externally.
module aes_decrypt_core (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            AES_START,
   input  logic [127:0]    AES_MSG_ENC,
   input  logic [1407:0]   KEY_SCHEDULE,
   input  logic            KS_VALID,
   input  logic [127:0]    SUB_OUT,
   output logic [127:0]    SUB_IN,
   output logic [127:0]    AES_MSG_DEC,
   output logic            AES_DONE
);

   typedef enum logic [3:0] {
      S_WAIT     = 4'd0,
      S_KEY_WAIT = 4'd1,
      S_ADD_INIT = 4'd2,
      S_SHIFT    = 4'd3,
      S_SUB      = 4'd4,
      S_ADD      = 4'd5,
      S_MIX0     = 4'd6,
      S_MIX1     = 4'd7,
      S_MIX2     = 4'd8,
      S_MIX3     = 4'd9,
      S_DONE     = 4'd10
   } state_t;

   state_t         state_q, state_d;
   logic [127:0]   blk_q, blk_d;
   logic [127:0]   dec_q, dec_d;
   logic [3:0]     rnd_q, rnd_d;
   logic           done_q, done_d;
   logic [127:0]   rk_s [0:10];
   logic [127:0]   rk_cur_s;

   for (genvar r = 0; r < 11; r++) begin : g_rk
      assign rk_s[r] = KEY_SCHEDULE[1407-128*r -: 128];
   end

   // ADD uses round key 10-RND, so the final round (RND=10) lands on the cipher key
   assign rk_cur_s = rk_s[4'd10 - rnd_q];

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 4; i++) begin
         p = p ^ (b[i] ? x : 8'h00);
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      a0 = c[31:24];
      a1 = c[23:16];
      a2 = c[15:8];
      a3 = c[7:0];
      return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
              gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
              gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
              gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
   endfunction

   // byte s(r,c) sits at bit 127-8*(4c+r); row r rotates right by r
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = 128'h0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

   // state register
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= S_WAIT;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_WAIT:     if (AES_START) state_d = S_KEY_WAIT; else state_d = S_WAIT;
         S_KEY_WAIT: if (KS_VALID)  state_d = S_ADD_INIT; else state_d = S_KEY_WAIT;
         S_ADD_INIT: state_d = S_SHIFT;
         S_SHIFT:    state_d = S_SUB;
         S_SUB:      state_d = S_ADD;
         S_ADD:      if (rnd_q == 4'd10) state_d = S_DONE; else state_d = S_MIX0;
         S_MIX0:     state_d = S_MIX1;
         S_MIX1:     state_d = S_MIX2;
         S_MIX2:     state_d = S_MIX3;
         S_MIX3:     state_d = S_SHIFT;
         S_DONE:     if (AES_START) state_d = S_DONE; else state_d = S_WAIT;
         default:    state_d = S_WAIT;
      endcase
   end

   // datapath and output next values
   always_comb begin
      blk_d = blk_q;
      rnd_d = rnd_q;
      dec_d = dec_q;
      case (state_q)
         S_ADD_INIT: begin
            blk_d = AES_MSG_ENC ^ rk_s[10];
            rnd_d = 4'd1;
         end
         S_SHIFT: blk_d = inv_shift_rows(blk_q);
         S_SUB:   blk_d = SUB_OUT;
         S_ADD: begin
            blk_d = blk_q ^ rk_cur_s;
            if (rnd_q == 4'd10) dec_d = blk_q ^ rk_cur_s;
            else                dec_d = dec_q;
         end
         S_MIX0: blk_d[127:96] = inv_mix_col(blk_q[127:96]);
         S_MIX1: blk_d[95:64]  = inv_mix_col(blk_q[95:64]);
         S_MIX2: blk_d[63:32]  = inv_mix_col(blk_q[63:32]);
         S_MIX3: begin
            blk_d[31:0] = inv_mix_col(blk_q[31:0]);
            rnd_d       = rnd_q + 4'd1;
         end
         default: begin
            blk_d = blk_q;
         end
      endcase
      done_d = (state_d == S_DONE);
   end

   // datapath registers
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         blk_q  <= 128'h0;
         dec_q  <= 128'h0;
         rnd_q  <= 4'd0;
         done_q <= 1'b0;
      end else begin
         blk_q  <= blk_d;
         dec_q  <= dec_d;
         rnd_q  <= rnd_d;
         done_q <= done_d;
      end
   end

   assign SUB_IN      = blk_q;
   assign AES_MSG_DEC = dec_q;
   assign AES_DONE    = done_q;

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Bench for aes_decrypt_core: behavioural key expansion, inverse S-box and
// inverse cipher; randomized and FIPS-197 vectors, handshake and reset cases.
module tb_aes_decrypt_core;

   logic            CLK = 1'b0;
   logic            RESET;
   logic            AES_START;
   logic [127:0]    AES_MSG_ENC;
   logic [1407:0]   KEY_SCHEDULE;
   logic            KS_VALID;
   logic [127:0]    SUB_OUT;
   logic [127:0]    SUB_IN;
   logic [127:0]    AES_MSG_DEC;
   logic            AES_DONE;

   int              checks = 0;
   int              errors = 0;
   logic [7:0]      sbox  [256];
   logic [7:0]      isbox [256];
   bit              tbl_ready = 1'b0;
   bit              sub_force = 1'b0;
   logic [127:0]    sub_force_val = 128'h0;
   logic [127:0]    last_dec = 128'h0;

   aes_decrypt_core dut (
      .CLK(CLK), .RESET(RESET), .AES_START(AES_START), .AES_MSG_ENC(AES_MSG_ENC),
      .KEY_SCHEDULE(KEY_SCHEDULE), .KS_VALID(KS_VALID), .SUB_OUT(SUB_OUT),
      .SUB_IN(SUB_IN), .AES_MSG_DEC(AES_MSG_DEC), .AES_DONE(AES_DONE)
   );

   always #5 CLK = ~CLK;

   always_comb begin
      SUB_OUT = 128'h0;
      if (sub_force) SUB_OUT = sub_force_val;
      else if (tbl_ready)
         for (int k = 0; k < 16; k++) SUB_OUT[127-8*k -: 8] = isbox[SUB_IN[127-8*k -: 8]];
   end

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return 8'((b << n) | (b >> (8 - n)));
   endfunction

   function automatic logic [1407:0] expand(input logic [127:0] key);
      logic [31:0]   w [44];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [1407:0] ks;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      ks = '0;
      for (int i = 0; i < 44; i++) ks[1407-32*i -: 32] = w[i];
      return ks;
   endfunction

   function automatic logic [31:0] ref_invmix(input logic [31:0] col);
      logic [7:0] a [4];
      logic [31:0] o;
      for (int r = 0; r < 4; r++) a[r] = col[31-8*r -: 8];
      for (int r = 0; r < 4; r++)
         o[31-8*r -: 8] = gmul(8'h0e, a[r]) ^ gmul(8'h0b, a[(r+1)%4]) ^
                          gmul(8'h0d, a[(r+2)%4]) ^ gmul(8'h09, a[(r+3)%4]);
      return o;
   endfunction

   // textbook inverse cipher on a 4x4 byte matrix s[row][col]
   function automatic logic [127:0] ref_dec(input logic [127:0] ct, input logic [1407:0] ks);
      logic [7:0]   s [4][4];
      logic [7:0]   t [4][4];
      logic [127:0] o;
      logic [31:0]  col;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            s[r][c] = ct[127-8*(4*c+r) -: 8] ^ ks[1407-128*10-8*(4*c+r) -: 8];
      for (int rnd = 9; rnd >= 0; rnd--) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) t[r][c] = s[r][(c-r+4)%4];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               s[r][c] = isbox[t[r][c]] ^ ks[1407-128*rnd-8*(4*c+r) -: 8];
         if (rnd > 0)
            for (int c = 0; c < 4; c++) begin
               col = ref_invmix({s[0][c], s[1][c], s[2][c], s[3][c]});
               for (int r = 0; r < 4; r++) s[r][c] = col[31-8*r -: 8];
            end
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) o[127-8*(4*c+r) -: 8] = s[r][c];
      return o;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // one decrypt run from WAIT; drop_at<0 keeps START high until after DONE
   task automatic run(input string tag, input logic [127:0] key, input logic [127:0] ct,
                      input int ks_delay, input int drop_at, input bit scramble);
      logic [1407:0] ks;
      logic [127:0]  exp;
      int            done_edge;
      ks = expand(key);
      exp = ref_dec(ct, ks);
      KEY_SCHEDULE = ks;
      AES_MSG_ENC = ct;
      KS_VALID = 1'b0;
      AES_START = 1'b1;
      done_edge = -1;
      for (int e = 0; e < 200 && done_edge < 0; e++) begin
         if (e == 1 + ks_delay)     KS_VALID = 1'b1;
         else if (e > 1 + ks_delay) KS_VALID = 1'($urandom_range(0, 1));
         else                       KS_VALID = 1'b0;
         if (e == drop_at) AES_START = 1'b0;
         tick();
         if (scramble && e == 2) AES_MSG_ENC = rnd128();
         if (e == 67 + ks_delay) chk({tag, "_dec_hold"}, AES_MSG_DEC, last_dec);
         if (AES_DONE) done_edge = e;
      end
      chk({tag, "_latency"}, 128'(done_edge), 128'(68 + ks_delay));
      chk({tag, "_result"}, AES_MSG_DEC, exp);
      if (drop_at < 0) begin
         tick();
         tick();
         chk({tag, "_done_hold"}, 128'(AES_DONE), 128'(1));
         chk({tag, "_dec_hold_done"}, AES_MSG_DEC, exp);
         AES_START = 1'b0;
      end
      tick();
      chk({tag, "_done_fall"}, 128'(AES_DONE), 128'(0));
      tick();
      chk({tag, "_dec_hold_wait"}, AES_MSG_DEC, exp);
      last_dec = exp;
   endtask

   initial begin
      logic [1407:0] ks;
      logic [127:0]  want;
      logic [7:0]    inv, b;
      int            done_seen;

      RESET = 1'b1;
      AES_START = 1'b0;
      KS_VALID = 1'b0;
      AES_MSG_ENC = 128'h0;
      KEY_SCHEDULE = '0;

      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         b = inv;
         sbox[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
      end
      for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);
      tbl_ready = 1'b1;

      tick();
      tick();
      chk("reset_sub_in", SUB_IN, 128'h0);
      chk("reset_dec", AES_MSG_DEC, 128'h0);
      chk("reset_done", 128'(AES_DONE), 128'(0));
      RESET = 1'b0;
      tick();

      run("fips", 128'h000102030405060708090a0b0c0d0e0f,
          128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, -1, 1'b0);
      chk("fips_const", AES_MSG_DEC, 128'h00112233445566778899aabbccddeeff);

      run("ks_delay", 128'h000102030405060708090a0b0c0d0e0f,
          128'h69c4e0d86a7b0430d8cdb78070b4c55a, 5, -1, 1'b0);
      chk("ks_delay_const", AES_MSG_DEC, 128'h00112233445566778899aabbccddeeff);

      run("isolate", rnd128(), rnd128(), 0, -1, 1'b1);
      run("start_drop", rnd128(), rnd128(), 2, 30, 1'b0);
      for (int i = 0; i < 3; i++) run("random", rnd128(), rnd128(), i, -1, 1'b0);

      // drive a chosen column into the state through SUB_OUT and watch the MIX states
      ks = expand(rnd128());
      KEY_SCHEDULE = ks;
      AES_MSG_ENC = rnd128();
      KS_VALID = 1'b1;
      AES_START = 1'b1;
      for (int e = 0; e < 4; e++) tick();
      want = {32'h8e4da1bc, $urandom, $urandom, $urandom};
      sub_force_val = want ^ ks[1407-128*9 -: 128];
      sub_force = 1'b1;
      tick();
      sub_force = 1'b0;
      tick();
      chk("mix_pre", SUB_IN, want);
      tick();
      want[127:96] = 32'hdb135345;
      chk("mix_col0", SUB_IN, want);
      for (int w = 1; w < 4; w++) begin
         tick();
         want[127-32*w -: 32] = ref_invmix(want[127-32*w -: 32]);
         chk("mix_colw", SUB_IN, want);
      end
      done_seen = 0;
      for (int e = 10; e < 200 && done_seen == 0; e++) begin
         tick();
         if (AES_DONE) done_seen = e;
      end
      chk("mix_run_latency", 128'(done_seen), 128'(68));
      AES_START = 1'b0;
      tick();

      // reset in the middle of a run, after a previous result exists
      KEY_SCHEDULE = expand(rnd128());
      AES_MSG_ENC = rnd128();
      KS_VALID = 1'b1;
      AES_START = 1'b1;
      for (int e = 0; e < 30; e++) tick();
      RESET = 1'b1;
      AES_START = 1'b0;
      #1;
      chk("rst_mid_done", 128'(AES_DONE), 128'(0));
      chk("rst_mid_dec", AES_MSG_DEC, 128'h0);
      chk("rst_mid_state", SUB_IN, 128'h0);
      tick();
      tick();
      RESET = 1'b0;
      for (int e = 0; e < 3; e++) tick();
      chk("rst_idle_state", SUB_IN, 128'h0);
      chk("rst_idle_done", 128'(AES_DONE), 128'(0));
      last_dec = 128'h0;
      run("after_reset", rnd128(), rnd128(), 0, -1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
